rescale_expander: RTL
=====================

// Module: rescale_expander
// PURPOSE
//  Inverse of the accumulator rescale/saturate stage. Takes signed int8 activations
//  and expands them back into the signed 32-bit accumulator domain:
//  (x <<< N), plus an optional half-LSB midpoint offset.
//  Feeds partial-sum re-injection and residual add paths.
//  Streaming, valid/ready on both sides, 2-stage pipeline, frame counter drives out_last.
// PARAMETERS
//  N          8'd11  left-shift amount; legal range 0..24 (elaborate-time $error outside)
//  ROUND_MID  1'b1   1: add 2^(N-1) after shift (only when N>0); 0: pure shift
//  FRAME_LEN  16'd64 outputs per frame; out_last on the FRAME_LEN-th; legal >=1
// PORTS
//  clk        in   1   clock, rising edge
//  rst_b      in   1   reset, asynchronous, active-low
//  clr        in   1   synchronous flush: empties pipeline, zeroes frame counter
//  in_valid   in   1   in_data valid
//  in_ready   out  1   stage 1 can accept this cycle
//  in_data    in   8   signed int8 activation
//  out_valid  out  1   out_data valid
//  out_ready  in   1   downstream accepts
//  out_data   out  32  signed expanded value
//  out_last   out  1   high with the final sample of a frame
//  frame_idx  out  16  index of the sample currently on out_data (0..FRAME_LEN-1)
// BEHAVIOUR
//  - Reset (rst_b=0, async): s1_valid=s2_valid=0, out_data=0, out_valid=0,
//    out_last=0, frame_idx=0.
//  - Fire: in_fire = in_valid&in_ready; out_fire = out_valid&out_ready.
//  - Stage 1 registers sign-extended in_data (32b).
//  - Stage 2 registers (s1 <<< N) + (ROUND_MID&&N>0 ? 2^(N-1) : 0).
//    No overflow is possible for N<=24, so no saturation logic.
//  - out_data/out_valid come from stage 2 registers. Latency: 2 clk from in_fire to
//    out_valid when unstalled. Throughput: 1 sample/clk.
//  - Advance rules: s2_adv = s1_valid & (~s2_valid | out_ready);
//    in_ready = ~s1_valid | s2_adv (combinational through out_ready; no bubbles at full rate).
//  - Stall: with out_ready=0 and both stages full, in_ready=0. out_data and out_last
//    are held stable while out_valid=1 and out_ready=0.
//  - frame_idx increments on out_fire and wraps to 0 after FRAME_LEN-1.
//    out_last = out_valid & (frame_idx==FRAME_LEN-1). With FRAME_LEN=1, every output is last.
//  - clr (sync) has priority over every fire in the same cycle: valids cleared, frame_idx=0,
//    and a coincident in_fire/out_fire is discarded. in_ready is forced 0 during clr.
//  - Async reset mid-stream: in-flight samples are dropped; no partial output after release.
//  - Invariant (ROUND_MID=1, N=11): feeding out_data into the rescale shifter returns the
//    original int8 for all 256 codes.
// STRUCTURE
//  - Shared package: ACC_W=32, ACT_W=8, the int8 min/max constants, and the
//    handshake fire macro/function.
//  - One natural sub-module: pipe_stage_reg (valid/data register with the advance rule).
//    Instantiated twice. Expansion arithmetic and frame counter live at top level.
// TESTING
//  - N=11, ROUND_MID=1, out_ready=1: in -128 -> out -261120 at +2 clk;
//    in 127 -> 261120; in 0 -> 1024.
//  - ROUND_MID=0, N=0: in -5 -> out 32'hFFFFFFFB. N=24: in -128 -> out 32'h80000000.
//  - Back-to-back 64 samples 0..63, FRAME_LEN=64: out_last only on sample 63;
//    frame_idx wraps to 0; 1 output/clk.
//  - out_ready low 5 clk mid-stream: in_ready drops after 2 accepts; out_data stable;
//    no loss or duplication, order preserved.
//  - clr asserted with both stages full and in_valid=1: next clk out_valid=0,
//    frame_idx=0, that input not accepted.
//  - Roundtrip sweep -128..127 through this block + rescale shifter (N=11):
//    identity; rst_b pulsed mid-sweep -> outputs 0/invalid, then clean restart.

Source files
------------

// File: rtl/rescale_expander_pkg.sv
// Shared widths, int8 range constants and the handshake helper for the
// rescale expander datapath.
package rescale_expander_pkg;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned ACT_W = 8;

  localparam logic signed [ACT_W-1:0] INT8_MIN = -8'sd128;
  localparam logic signed [ACT_W-1:0] INT8_MAX = 8'sd127;

  typedef logic [ACC_W-1:0] acc_t;
  typedef logic [ACT_W-1:0] act_t;

  function automatic logic fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/rescale_expander_pipe_stage.sv
// Valid/data pipeline register: loads on advance, empties on drain,
// clr flushes the valid bit ahead of any load or drain.
module pipe_stage_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (clr)        valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (drain) valid <= 1'b0;

      if (load && !clr) q <= d;
    end
  end

endmodule

// File: rtl/rescale_expander.sv
// Expands signed int8 activations into the 32-bit accumulator domain:
// (x <<< N) plus an optional half-LSB midpoint, two-stage valid/ready pipe.
module rescale_expander
  import rescale_expander_pkg::*;
#(
  parameter int unsigned N         = 11,
  parameter bit          ROUND_MID = 1'b1,
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic [15:0]      frame_idx
);

  if (N > 24) begin : g_bad_n
    $error("rescale_expander: N=%0d outside 0..24", N);
  end
  if (FRAME_LEN < 1) begin : g_bad_frame
    $error("rescale_expander: FRAME_LEN must be >= 1");
  end

  // Midpoint offset is 2^(N-1); RSH keeps the shift amount legal when N=0.
  localparam int unsigned RSH      = (N > 0) ? N - 1 : 0;
  localparam acc_t        OFFSET   = (ROUND_MID && N > 0) ? (acc_t'(1) << RSH) : '0;
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  logic s1_valid;
  logic s2_valid;
  acc_t s1_d;
  acc_t s1_q;
  acc_t s2_d;
  logic s2_adv;
  logic in_fire;
  logic out_fire;

  always_comb begin
    s2_adv   = s1_valid & (~s2_valid | out_ready);
    in_ready = ~clr & (~s1_valid | s2_adv);
    in_fire  = fire(in_valid, in_ready);
    out_fire = fire(s2_valid, out_ready) & ~clr;
  end

  assign s1_d = {{(ACC_W - ACT_W){in_data[ACT_W-1]}}, in_data};
  assign s2_d = (s1_q << N) + OFFSET;

  pipe_stage_reg #(.W(ACC_W)) u_stage1 (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (clr),
    .load  (in_fire),
    .drain (s2_adv),
    .d     (s1_d),
    .valid (s1_valid),
    .q     (s1_q)
  );

  pipe_stage_reg #(.W(ACC_W)) u_stage2 (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (clr),
    .load  (s2_adv),
    .drain (out_fire),
    .d     (s2_d),
    .valid (s2_valid),
    .q     (out_data)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      frame_idx <= '0;
    end else if (clr) begin
      frame_idx <= '0;
    end else if (out_fire) begin
      frame_idx <= (frame_idx == LAST_IDX) ? '0 : frame_idx + 16'd1;
    end
  end

  assign out_valid = s2_valid;
  assign out_last  = s2_valid & (frame_idx == LAST_IDX);

endmodule
